// File: rtl/memory_arb_pkg.sv
// Shared types and default sizes for the memory port arbiter.
package memory_arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_DEPTH  = 4096;

    typedef enum logic {
        REQ_CORE   = 1'b0,
        REQ_LOADER = 1'b1
    } req_id_t;

    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic                  lock;
    } req_t;

    function automatic req_id_t other_req(input req_id_t id);
        return (id == REQ_CORE) ? REQ_LOADER : REQ_CORE;
    endfunction

endpackage

// File: rtl/rr_grant2.sv
// Two-way round-robin grant with a bounded lock counter that lets one
// requester keep priority for up to MAX_LOCK consecutive grants.
module rr_grant2
    import memory_arb_pkg::*;
#(
    parameter int MAX_LOCK = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic [1:0] lock,
    output logic [1:0] grant
);

    localparam int CNT_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK + 1) : 1;

    req_id_t          prio_reg;
    req_id_t          last_reg;
    logic [CNT_W-1:0] lock_cnt_reg;

    req_id_t          gid;
    logic             gid_lock;
    logic [CNT_W-1:0] eff_cnt;

    always_comb begin
        grant = 2'b00;
        if (!rst) begin
            if (valid == 2'b11) begin
                grant = (prio_reg == REQ_LOADER) ? 2'b10 : 2'b01;
            end else begin
                grant = valid;
            end
        end
    end

    assign gid      = grant[1] ? REQ_LOADER : REQ_CORE;
    assign gid_lock = grant[1] ? lock[1] : lock[0];
    // The counter only belongs to the requester that earned it; a switch restarts it.
    assign eff_cnt  = (gid == last_reg) ? lock_cnt_reg : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_reg     <= REQ_CORE;
            last_reg     <= REQ_CORE;
            lock_cnt_reg <= '0;
        end else if (grant != 2'b00) begin
            last_reg <= gid;
            if (gid_lock && (int'(eff_cnt) < MAX_LOCK - 1)) begin
                prio_reg     <= gid;
                lock_cnt_reg <= eff_cnt + 1'b1;
            end else begin
                prio_reg     <= other_req(gid);
                lock_cnt_reg <= '0;
            end
        end else begin
            lock_cnt_reg <= '0;
        end
    end

endmodule

// File: rtl/memory_port_arbiter.sv
// Arbitrates one memory port between the core (req0) and loader (req1) and
// returns read data one cycle later. Optional: MEMORY_ARB_RANGE_CHECK_EN.
module memory_port_arbiter
    import memory_arb_pkg::*;
#(
    parameter int ADDR_W   = ARB_ADDR_W,
    parameter int DATA_W   = ARB_DATA_W,
    parameter int DEPTH    = ARB_DEPTH,
    parameter int MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req0_lock,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic              req1_lock,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,
    output logic              memory_write_enable,
    output logic [ADDR_W-1:0] memory_access_address,
    output logic [DATA_W-1:0] memory_write_data,
    input  logic [DATA_W-1:0] memory_read_data
);

    if (MAX_LOCK < 1 || DEPTH < 1 || ADDR_W > ARB_ADDR_W || DATA_W > ARB_DATA_W) begin : g_bad_params
        $error("memory_port_arbiter: unsupported parameter combination");
    end

    req_t        req [2];
    logic [1:0]  valid_vec;
    logic [1:0]  lock_vec;
    logic [1:0]  grant;

    assign req[0] = '{we: req0_we, addr: ARB_ADDR_W'(req0_addr),
                      wdata: ARB_DATA_W'(req0_wdata), lock: req0_lock};
    assign req[1] = '{we: req1_we, addr: ARB_ADDR_W'(req1_addr),
                      wdata: ARB_DATA_W'(req1_wdata), lock: req1_lock};
    assign valid_vec = {req1_valid, req0_valid};

    for (genvar gi = 0; gi < 2; gi++) begin : g_lock
        assign lock_vec[gi] = req[gi].lock;
    end

    rr_grant2 #(.MAX_LOCK(MAX_LOCK)) u_grant (
        .clk   (clk),
        .rst   (rst),
        .valid (valid_vec),
        .lock  (lock_vec),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              out_of_range;

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (grant[1]) begin
            sel_we    = req[1].we;
            sel_addr  = ADDR_W'(req[1].addr);
            sel_wdata = DATA_W'(req[1].wdata);
        end else if (grant[0]) begin
            sel_we    = req[0].we;
            sel_addr  = ADDR_W'(req[0].addr);
            sel_wdata = DATA_W'(req[0].wdata);
        end
    end

`ifdef MEMORY_ARB_RANGE_CHECK_EN
    assign out_of_range = (grant != 2'b00) && (64'(sel_addr) >= 64'(DEPTH));
`else
    assign out_of_range = 1'b0;
`endif

    assign memory_write_enable   = sel_we & ~out_of_range;
    assign memory_access_address = out_of_range ? '0 : sel_addr;
    assign memory_write_data     = sel_wdata;

    logic    pending_reg;
    req_id_t owner_reg;
    logic    err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_reg <= 1'b0;
            owner_reg   <= REQ_CORE;
            err_reg     <= 1'b0;
        end else begin
            pending_reg <= (grant != 2'b00);
            err_reg     <= out_of_range;
            if (grant != 2'b00) begin
                owner_reg <= grant[1] ? REQ_LOADER : REQ_CORE;
            end
        end
    end

    // Read data is broadcast; only the owner's valid qualifies it.
    assign rsp0_valid = pending_reg && (owner_reg == REQ_CORE);
    assign rsp1_valid = pending_reg && (owner_reg == REQ_LOADER);
    assign rsp0_err   = rsp0_valid && err_reg;
    assign rsp1_err   = rsp1_valid && err_reg;
    assign rsp0_rdata = err_reg ? '0 : memory_read_data;
    assign rsp1_rdata = err_reg ? '0 : memory_read_data;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Randomized self-checking bench for memory_port_arbiter against a behavioural
// arbitration and memory model.
module tb_memory_port_arbiter;

    localparam int MAX_LOCK = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req0_we = 1'b0, req0_lock = 1'b0;
    logic        req1_valid = 1'b0, req1_we = 1'b0, req1_lock = 1'b0;
    logic [31:0] req0_addr = '0, req0_wdata = '0, req1_addr = '0, req1_wdata = '0;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        memory_write_enable;
    logic [31:0] memory_access_address, memory_write_data;
    logic [31:0] memory_read_data;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    memory_port_arbiter #(.MAX_LOCK(MAX_LOCK)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .req0_valid            (req0_valid),
        .req0_ready            (req0_ready),
        .req0_we               (req0_we),
        .req0_addr             (req0_addr),
        .req0_wdata            (req0_wdata),
        .req0_lock             (req0_lock),
        .rsp0_valid            (rsp0_valid),
        .rsp0_rdata            (rsp0_rdata),
        .rsp0_err              (rsp0_err),
        .req1_valid            (req1_valid),
        .req1_ready            (req1_ready),
        .req1_we               (req1_we),
        .req1_addr             (req1_addr),
        .req1_wdata            (req1_wdata),
        .req1_lock             (req1_lock),
        .rsp1_valid            (rsp1_valid),
        .rsp1_rdata            (rsp1_rdata),
        .rsp1_err              (rsp1_err),
        .memory_write_enable   (memory_write_enable),
        .memory_access_address (memory_access_address),
        .memory_write_data     (memory_write_data),
        .memory_read_data      (memory_read_data)
    );

    function automatic logic [31:0] init_word(input int a);
        return 32'(a) ^ 32'hA5A5_0000;
    endfunction

    // Write-first memory with one cycle of read latency, attached to the DUT port.
    logic [31:0] tb_mem [256];
    always @(posedge clk) begin
        if (memory_write_enable) begin
            tb_mem[memory_access_address[7:0]] <= memory_write_data;
            memory_read_data <= memory_write_data;
        end else begin
            memory_read_data <= tb_mem[memory_access_address[7:0]];
        end
    end

    // Reference state: what the memory should hold and who should win next.
    logic [31:0] model_mem [256];
    int m_prio = 0;
    int m_last = 0;
    int m_streak = 0;
    int wait0 = 0;
    int wait1 = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit r,
                        input bit v0, input bit w0, input logic [31:0] a0, input logic [31:0] d0, input bit l0,
                        input bit v1, input bit w1, input logic [31:0] a1, input logic [31:0] d1, input bit l1,
                        output int gdut);
        int          g;
        bit          ew;
        bit          lk;
        logic [31:0] ea, ed, exp_rd;
        @(negedge clk);
        rst = r;
        req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0; req0_lock = l0;
        req1_valid = v1; req1_we = w1; req1_addr = a1; req1_wdata = d1; req1_lock = l1;
        #1;
        if (r) g = -1;
        else if (v0 && v1) g = m_prio;
        else if (v0) g = 0;
        else if (v1) g = 1;
        else g = -1;
        gdut = req1_ready ? 1 : (req0_ready ? 0 : -1);
        check("req0_ready", 64'(req0_ready), 64'(g == 0));
        check("req1_ready", 64'(req1_ready), 64'(g == 1));
        ew = 1'b0; ea = '0; ed = '0; lk = 1'b0;
        if (g == 0) begin ew = w0; ea = a0; ed = d0; lk = l0; end
        else if (g == 1) begin ew = w1; ea = a1; ed = d1; lk = l1; end
        check("mem_we", 64'(memory_write_enable), 64'(ew));
        check("mem_addr", 64'(memory_access_address), 64'(ea));
        check("mem_wdata", 64'(memory_write_data), 64'(ed));

        // A contending requester must be served within MAX_LOCK cycles.
        wait0 = (!r && v0 && gdut != 0) ? wait0 + 1 : 0;
        wait1 = (!r && v1 && gdut != 1) ? wait1 + 1 : 0;
        if (!r && v0) check("starve0", 64'(wait0 <= MAX_LOCK), 64'd1);
        if (!r && v1) check("starve1", 64'(wait1 <= MAX_LOCK), 64'd1);

        exp_rd = '0;
        if (g >= 0) begin
            exp_rd = ew ? ed : model_mem[ea[7:0]];
            if (ew) model_mem[ea[7:0]] = ed;
        end
        if (r) begin
            m_prio = 0; m_last = 0; m_streak = 0;
        end else if (g < 0) begin
            m_streak = 0;
        end else begin
            if (g != m_last) m_streak = 0;
            if (lk && m_streak < MAX_LOCK - 1) begin
                m_streak++;
                m_prio = g;
            end else begin
                m_streak = 0;
                m_prio = 1 - g;
            end
            m_last = g;
        end

        @(posedge clk);
        #1;
        check("rsp0_valid", 64'(rsp0_valid), 64'(g == 0));
        check("rsp1_valid", 64'(rsp1_valid), 64'(g == 1));
        check("rsp0_err", 64'(rsp0_err), 64'd0);
        check("rsp1_err", 64'(rsp1_err), 64'd0);
        if (g >= 0) begin
            check("rsp0_rdata", 64'(rsp0_rdata), 64'(exp_rd));
            check("rsp1_rdata", 64'(rsp1_rdata), 64'(exp_rd));
        end
    endtask

    initial begin
        int gd;
        int seq_cont [4];
        int seq_lock [6];
        seq_cont = '{0, 1, 0, 1};
        seq_lock = '{1, 1, 1, 1, 0, 1};
        for (int i = 0; i < 256; i++) begin
            tb_mem[i]    = init_word(i);
            model_mem[i] = init_word(i);
        end

        // Reset held with both requesters pushing.
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 32'h1, 32'h0, 0, 1, 0, 32'h2, 32'h0, 0, gd);
            check("reset_grant", 64'(gd), 64'(-1));
        end

        // Continuous contention without lock alternates, starting with req0.
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 32'(i), 32'h0, 0, 1, 0, 32'(i + 8), 32'h0, 0, gd);
            check("contention_seq", 64'(gd), 64'(seq_cont[i]));
        end

        // Preload 0xDEADBEEF via the loader, then a single core read.
        step(0, 0, 0, 32'h0, 32'h0, 0, 1, 1, 32'h10, 32'hDEADBEEF, 0, gd);
        step(0, 1, 0, 32'h10, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, gd);
        check("single_read_grant", 64'(gd), 64'd0);
        check("single_read_data", 64'(rsp0_rdata), 64'h0000_0000_DEAD_BEEF);
        check("single_read_rsp1", 64'(rsp1_valid), 64'd0);

        // Core writes, loader reads the same word next cycle.
        step(0, 1, 1, 32'h20, 32'h12345678, 0, 0, 0, 32'h0, 32'h0, 0, gd);
        check("write_echo", 64'(rsp0_rdata), 64'h0000_0000_1234_5678);
        step(0, 0, 0, 32'h0, 32'h0, 0, 1, 0, 32'h20, 32'h0, 0, gd);
        check("read_after_write", 64'(rsp1_rdata), 64'h0000_0000_1234_5678);

        // Hand priority to req1, then let it lock against a contending req0.
        step(0, 1, 0, 32'h3, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, gd);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0, 32'(i + 40), 32'h0, 0, 1, 0, 32'(i + 50), 32'h0, 1, gd);
            check("lock_seq", 64'(gd), 64'(seq_lock[i]));
        end

        // Reset right after a write drops the pending response.
        step(0, 1, 1, 32'h30, 32'hCAFE0001, 0, 0, 0, 32'h0, 32'h0, 0, gd);
        step(1, 1, 0, 32'h30, 32'h0, 0, 1, 0, 32'h30, 32'h0, 0, gd);
        check("post_reset_rsp0", 64'(rsp0_valid), 64'd0);
        step(0, 1, 0, 32'h30, 32'h0, 1, 1, 0, 32'h31, 32'h0, 1, gd);
        check("post_reset_grant", 64'(gd), 64'd0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 9) < 7, 1'($urandom), 32'($urandom_range(0, 255)), $urandom,
                 $urandom_range(0, 9) < 3,
                 $urandom_range(0, 9) < 7, 1'($urandom), 32'($urandom_range(0, 255)), $urandom,
                 $urandom_range(0, 9) < 4,
                 gd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
